// File: rtl/wb_arb_pkg.sv
//------------------------------------------------------------------------------
// wb_arb_pkg : shared state encoding and width helpers for the Wishbone arbiter
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, searches upward from last+1
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import wb_arb_pkg::*;
#(
  parameter  int NUMM = 2,
  localparam int IDXW = idx_w(NUMM)
) (
  input  logic [NUMM-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [NUMM-1:0] onehot_o,
  output logic [IDXW-1:0] idx_o
);

  always_comb begin
    logic            found;
    logic [IDXW-1:0] cand;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    // offset NUMM wraps back to last itself, so the previous owner is tried last
    for (int k = 1; k <= NUMM; k++) begin
      cand = IDXW'((int'(last_i) + k) % NUMM);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_rr.sv
//------------------------------------------------------------------------------
// wb_arbiter_rr : round-robin Wishbone bus-ownership scheduler with
//                 outstanding-request tracking; WB_ARB_TIMEOUT_EN adds a watchdog
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter  int NUMM            = 2,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int TIMEOUT         = 255,
  localparam int IDXW            = idx_w(NUMM),
  localparam int CNTW            = cnt_w(MAX_OUTSTANDING)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NUMM-1:0] req_cyc,
  input  logic            bus_stb,
  input  logic            bus_stall,
  input  logic            bus_ack,
  input  logic            bus_err,
  output logic [NUMM-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic            stb_mask,
  output logic [CNTW-1:0] outstanding,
  output logic            to_err
);

  arb_state_e      state_q;
  logic [NUMM-1:0] gnt_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] last_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  logic [NUMM-1:0] pick_oh;
  logic [IDXW-1:0] pick_idx;
  logic            owned;
  logic            owner_cyc;
  logic            accept;
  logic            complete;
  logic            timeout_hit;

  rr_pick #(.NUMM(NUMM)) u_pick (
    .req_i    (req_cyc),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  assign owned     = (state_q == OWNED);
  assign owner_cyc = req_cyc[idx_q];
  assign stb_mask  = (cnt_q == CNTW'(MAX_OUTSTANDING));
  assign accept    = owned & bus_stb & ~bus_stall & ~stb_mask;
  assign complete  = owned & (bus_ack | bus_err);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !complete) begin
      cnt_d = cnt_q + 1'b1;
    end else if (complete && !accept && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDXW'(NUMM - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (|req_cyc) begin
            gnt_q   <= pick_oh;
            idx_q   <= pick_idx;
            last_q  <= pick_idx;
            state_q <= OWNED;
          end
        end
        OWNED: begin
          // dropping cyc abandons whatever is still pending
          if (!owner_cyc || timeout_hit) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_d;
  logic           to_err_q;

  always_comb begin
    wd_d        = wd_q;
    timeout_hit = 1'b0;
    if (owned && complete) begin
      wd_d = '0;
    end else if (owned && (cnt_q != '0)) begin
      wd_d = wd_q + 1'b1;
      if (owner_cyc && (wd_q == WDW'(TIMEOUT - 1))) begin
        timeout_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !owned || !owner_cyc || timeout_hit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
    to_err_q <= rst_n & timeout_hit;
  end

  assign to_err = to_err_q;
`else
  assign timeout_hit = 1'b0;
  assign to_err      = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign gnt_valid   = |gnt_q;
  assign gnt_idx     = idx_q;
  assign outstanding = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    a_params: assert (NUMM >= 2 && MAX_OUTSTANDING >= 1 && TIMEOUT >= 1);
    if (rst_n) begin
      a_gnt_onehot0: assert ($onehot0(gnt_q));
      a_cnt_bound:   assert (cnt_q <= CNTW'(MAX_OUTSTANDING));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
//------------------------------------------------------------------------------
// tb_wb_arbiter_rr : directed + random bench for wb_arbiter_rr against a
//                    cycle-level reference model of the ownership rules
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter_rr;

  localparam int NUMM = 2;
  localparam int MAXO = 4;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_cyc;
  logic       bus_stb, bus_stall, bus_ack, bus_err;
  logic [1:0] gnt;
  logic       gnt_valid;
  logic [0:0] gnt_idx;
  logic       stb_mask;
  logic [2:0] outstanding;
  logic       to_err;

  wb_arbiter_rr #(
    .NUMM            (NUMM),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT         (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_cyc     (req_cyc),
    .bus_stb     (bus_stb),
    .bus_stall   (bus_stall),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .stb_mask    (stb_mask),
    .outstanding (outstanding),
    .to_err      (to_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: owner (-1 = nobody), last winner, pending count, watchdog
  int m_owner = -1;
  int m_last  = NUMM - 1;
  int m_cnt   = 0;
  int m_wd    = 0;
  bit m_toerr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    check("gnt",         32'(gnt),         (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("gnt_valid",   32'(gnt_valid),   32'(m_owner >= 0));
    check("gnt_idx",     32'(gnt_idx),     (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("outstanding", 32'(outstanding), 32'(m_cnt));
    check("stb_mask",    32'(stb_mask),    32'(m_cnt == MAXO));
    check("to_err",      32'(to_err),      32'(m_toerr));
  endtask

  task automatic model_step();
    int c;
    bit acc, cmp;
    if (!rst_n) begin
      m_owner = -1; m_last = NUMM - 1; m_cnt = 0; m_wd = 0; m_toerr = 1'b0;
    end else if (m_owner < 0) begin
      m_toerr = 1'b0;
      m_cnt   = 0;
      for (int k = 1; k <= NUMM; k++) begin
        c = (m_last + k) % NUMM;
        if (m_owner < 0 && req_cyc[c]) begin
          m_owner = c;
          m_last  = c;
        end
      end
    end else begin
      m_toerr = 1'b0;
      acc = bus_stb && !bus_stall && (m_cnt < MAXO);
      cmp = bus_ack || bus_err;
      if (!req_cyc[m_owner]) begin
        m_owner = -1; m_cnt = 0; m_wd = 0;
      end else begin
`ifdef WB_ARB_TIMEOUT_EN
        if (cmp) m_wd = 0;
        else if (m_cnt > 0) m_wd++;
`endif
        if (acc && !cmp) m_cnt++;
        else if (cmp && !acc && m_cnt > 0) m_cnt--;
`ifdef WB_ARB_TIMEOUT_EN
        if (m_wd == TO) begin
          m_toerr = 1'b1; m_owner = -1; m_cnt = 0; m_wd = 0;
        end
`endif
      end
    end
  endtask

  // apply inputs for one cycle, check outputs against the model, advance a clock
  task automatic cyc(input logic r, input logic [1:0] req, input logic stb,
                     input logic stall, input logic ack, input logic err);
    rst_n = r; req_cyc = req; bus_stb = stb; bus_stall = stall; bus_ack = ack; bus_err = err;
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         h, idle_run;
    int         seq[$];
    logic       pv;
    logic [1:0] r;

    rst_n = 1'b0; req_cyc = '0; bus_stb = 0; bus_stall = 0; bus_ack = 0; bus_err = 0;
    @(posedge clk);
    #1;
    cyc(0, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0);

    // first arbitration goes to master 0, release leaves one dead cycle
    cyc(1, 2'b11, 0, 0, 0, 0);
    check("t1_gnt_c1", 32'(gnt), 32'b01);
    repeat (4) cyc(1, 2'b11, 0, 0, 0, 0);
    cyc(1, 2'b10, 0, 0, 0, 0);
    check("t1_gnt_c6", 32'(gnt), 32'b00);
    cyc(1, 2'b10, 0, 0, 0, 0);
    check("t1_gnt_c7", 32'(gnt), 32'b10);

    // continuous requests, each owner releases after 3 cycles
    h = 0; idle_run = 0; pv = gnt_valid;
    for (int i = 0; i < 30; i++) begin
      if (gnt_valid && !pv) begin
        seq.push_back(int'(gnt_idx));
        check("rr_dead_cycle", 32'(idle_run), 32'd1);
      end
      idle_run = gnt_valid ? 0 : idle_run + 1;
      pv = gnt_valid;
      r  = 2'b11;
      if (gnt_valid) begin
        h++;
        if (h == 3) begin
          r[gnt_idx] = 1'b0;
          h = 0;
        end
      end else begin
        h = 0;
      end
      cyc(1, r, 0, 0, 0, 0);
    end
    check("rr_seq_len", 32'(seq.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < seq.size(); k++)
      check("rr_seq", 32'(seq[k]), 32'(k % 2));

    // outstanding saturation and masking
    cyc(1, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 0);
    repeat (4) cyc(1, 2'b01, 1, 0, 0, 0);
    check("sat_cnt", 32'(outstanding), 32'd4);
    check("sat_mask", 32'(stb_mask), 32'd1);
    cyc(1, 2'b01, 1, 0, 0, 0);
    check("sat_blocked", 32'(outstanding), 32'd4);
    cyc(1, 2'b01, 0, 0, 1, 0);
    check("ack_cnt", 32'(outstanding), 32'd3);
    check("ack_mask", 32'(stb_mask), 32'd0);
    cyc(1, 2'b01, 1, 0, 1, 0);
    check("acc_ack_cnt", 32'(outstanding), 32'd3);
    cyc(1, 2'b01, 1, 1, 0, 0);
    check("stall_cnt", 32'(outstanding), 32'd3);

    // drain, ack at zero, abandon with count 2
    cyc(1, 2'b01, 0, 0, 1, 0);
    cyc(1, 2'b01, 0, 0, 0, 1);
    cyc(1, 2'b01, 0, 0, 1, 0);
    cyc(1, 2'b01, 0, 0, 1, 0);
    check("underflow", 32'(outstanding), 32'd0);
    cyc(1, 2'b01, 1, 0, 0, 0);
    cyc(1, 2'b01, 1, 0, 0, 0);
    check("cnt2", 32'(outstanding), 32'd2);
    cyc(1, 2'b00, 0, 0, 0, 0);
    check("abandon_cnt", 32'(outstanding), 32'd0);
    check("abandon_gnt", 32'(gnt), 32'd0);

    // watchdog: one accept, slave never answers
    cyc(1, 2'b01, 0, 0, 0, 0);
    cyc(1, 2'b01, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
`ifdef WB_ARB_TIMEOUT_EN
      check("wd_to_err", 32'(to_err), 32'(i == 8));
      if (i <= 8) check("wd_gnt_valid", 32'(gnt_valid), 32'(i < 8));
`else
      check("wd_to_err", 32'(to_err), 32'd0);
      check("wd_gnt_held", 32'(gnt_valid), 32'd1);
`endif
      cyc(1, 2'b01, 0, 0, 0, 0);
    end
    cyc(1, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0);

    // reset while master 1 owns with three pending
    cyc(1, 2'b10, 0, 0, 0, 0);
    repeat (3) cyc(1, 2'b10, 1, 0, 0, 0);
    check("pre_rst_cnt", 32'(outstanding), 32'd3);
    check("pre_rst_gnt", 32'(gnt), 32'b10);
    cyc(0, 2'b11, 0, 0, 0, 0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_cnt", 32'(outstanding), 32'd0);
    cyc(1, 2'b11, 0, 0, 0, 0);
    check("post_rst_gnt", 32'(gnt), 32'b01);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = 2'($urandom_range(0, 3));
      if (gnt_valid && $urandom_range(0, 7) != 0) r[gnt_idx] = 1'b1;
      cyc(($urandom_range(0, 63) != 0), r, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0));
    end
    model_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
